// File: rtl/arm_clock_reader.sv
// rtl/arm_clock_reader.sv - CPU read/compare block for the free-running count (optional: ARM_CLOCK_READER_DELTA_EN)
module arm_clock_reader #(
   parameter int unsigned ADDR_W    = 3,
   parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
   input  logic              cnt_clk,
   input  logic              cnt_resetn,
   input  logic [31:0]       cnt_value,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              irq
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] snap;
   logic [31:0] cmp;
   logic [31:0] cnt_prev;
   logic [31:0] rd_data;
   logic        irq_en;
   logic        pending;
   logic        armed;
   logic        accept;
   logic        mapped;
   logic        tick;
   logic        match;
   logic [2:0]  idx;
   logic        wr_snap;
   logic        wr_cmp;
   logic        wr_ctrl;

   // Only the low three address bits select a register; any upper bit set makes the access unmapped.
   assign mapped  = (req_addr >> 3) == '0;
   assign idx     = req_addr[2:0];
   assign accept  = req_valid & req_ready;
   assign wr_snap = accept & req_write & mapped & (idx == 3'd1);
   assign wr_cmp  = accept & req_write & mapped & (idx == 3'd2);
   assign wr_ctrl = accept & req_write & mapped & (idx == 3'd3);

   // A match needs a count change, so a static count never re-fires the one-shot.
   assign tick  = (cnt_value != cnt_prev);
   assign match = tick & armed & (cnt_value == cmp);

   // Handshake FSM: accept in IDLE, hold the response in RESP until consumed.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Read mux, evaluated with the count present in the accept cycle.
   always_comb begin
      rd_data = '0;
      if (mapped) begin
         case (idx)
            3'd0: rd_data = cnt_value;
            3'd1: rd_data = snap;
            3'd2: rd_data = cmp;
            3'd3: rd_data = {29'b0, armed, pending, irq_en};
`ifdef ARM_CLOCK_READER_DELTA_EN
            3'd4: rd_data = cnt_value - snap;
`endif
            default: rd_data = '0;
         endcase
      end
   end

   // FSM state register and the registered response data.
   always_ff @(posedge cnt_clk) begin
      if (!cnt_resetn) begin
         state      <= IDLE;
         resp_rdata <= '0;
      end else begin
         state <= state_next;
         if (accept) resp_rdata <= req_write ? 32'h0 : rd_data;
      end
   end

   // Register file, compare state and interrupt; match beats a W1C, a CMP write beats match on armed.
   always_ff @(posedge cnt_clk) begin
      if (!cnt_resetn) begin
         snap     <= '0;
         cmp      <= CMP_RESET;
         irq_en   <= 1'b0;
         pending  <= 1'b0;
         armed    <= 1'b0;
         cnt_prev <= '0;
         irq      <= 1'b0;
      end else begin
         cnt_prev <= cnt_value;
         if (wr_snap) snap <= cnt_value;
         if (wr_cmp) cmp <= req_wdata;
         if (wr_ctrl) irq_en <= req_wdata[0];
         if (match) pending <= 1'b1;
         else if (wr_ctrl && req_wdata[1]) pending <= 1'b0;
         if (wr_cmp) armed <= 1'b1;
         else if (match) armed <= 1'b0;
         irq <= pending & irq_en;
      end
   end

endmodule

// File: tb/tb_arm_clock_reader.sv
// tb/tb_arm_clock_reader.sv - self-checking bench for arm_clock_reader
module tb_arm_clock_reader;

   logic        cnt_clk = 1'b0;
   logic        cnt_resetn;
   logic [31:0] cnt_value;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Reference state, advanced once per clock from the register-map rules.
   logic [31:0] m_snap, m_cmp, m_prev, m_rdata;
   logic        m_en, m_pend, m_armed, m_irq, m_busy;

   arm_clock_reader dut (
      .cnt_clk    (cnt_clk),
      .cnt_resetn (cnt_resetn),
      .cnt_value  (cnt_value),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .irq        (irq)
   );

   // Free-running clock.
   always #5 cnt_clk = ~cnt_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return cnt_value;
         3'd1: return m_snap;
         3'd2: return m_cmp;
         3'd3: return {29'b0, m_armed, m_pend, m_en};
`ifdef ARM_CLOCK_READER_DELTA_EN
         3'd4: return cnt_value - m_snap;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic step();
      logic        acc, wr, hit, n_en, n_pend, n_armed, n_busy, n_irq;
      logic [31:0] n_snap, n_cmp, n_rdata, n_prev;
      acc     = req_valid && !m_busy;
      wr      = acc && req_write;
      hit     = (cnt_value != m_prev) && m_armed && (cnt_value == m_cmp);
      n_snap  = (wr && req_addr == 3'd1) ? cnt_value : m_snap;
      n_cmp   = (wr && req_addr == 3'd2) ? req_wdata : m_cmp;
      n_en    = (wr && req_addr == 3'd3) ? req_wdata[0] : m_en;
      n_pend  = hit ? 1'b1 : ((wr && req_addr == 3'd3 && req_wdata[1]) ? 1'b0 : m_pend);
      n_armed = (wr && req_addr == 3'd2) ? 1'b1 : (hit ? 1'b0 : m_armed);
      n_rdata = acc ? (req_write ? 32'h0 : model_read(req_addr)) : m_rdata;
      n_busy  = acc ? 1'b1 : ((m_busy && resp_ready) ? 1'b0 : m_busy);
      n_irq   = m_pend && m_en;
      n_prev  = cnt_value;
      if (!cnt_resetn) begin
         n_snap = 32'h0; n_cmp = 32'hFFFF_FFFF; n_en = 1'b0; n_pend = 1'b0; n_armed = 1'b0;
         n_rdata = 32'h0; n_busy = 1'b0; n_irq = 1'b0; n_prev = 32'h0;
      end
      @(posedge cnt_clk);
      #1;
      m_snap = n_snap; m_cmp = n_cmp; m_en = n_en; m_pend = n_pend; m_armed = n_armed;
      m_rdata = n_rdata; m_busy = n_busy; m_irq = n_irq; m_prev = n_prev;
   endtask

   task automatic txn(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input string tag, output logic [31:0] rd);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b1;
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".rdata"}, resp_rdata, m_rdata);
      rd = resp_rdata;
      step();
      check({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic ramp(input string tag);
      for (int v = 1; v <= 8; v++) begin
         cnt_value = 32'(v);
         for (int j = 0; j < 4; j++) begin
            step();
            check({tag, ".irq"}, 32'(irq), 32'(m_irq));
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [2:0]  a;
      logic        w;
      logic [31:0] d;

      cnt_resetn = 1'b0; cnt_value = 32'h0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 3'd0; req_wdata = 32'h0; resp_ready = 1'b1;
      m_busy = 1'b0;
      repeat (3) step();
      cnt_resetn = 1'b1;
      step();
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.irq", 32'(irq), 32'd0);
      check("rst.rdata", resp_rdata, 32'h0);

      txn(1'b0, 3'd3, 32'h0, "rd_ctrl", rd);
      check("rd_ctrl.val", rd, 32'h0);
      txn(1'b0, 3'd2, 32'h0, "rd_cmp", rd);
      check("rd_cmp.val", rd, 32'hFFFF_FFFF);

      cnt_value = 32'h1234;
      txn(1'b1, 3'd1, 32'hDEAD_BEEF, "wr_snap", rd);
      check("wr_snap.zero", rd, 32'h0);
      cnt_value = 32'h1300;
      txn(1'b0, 3'd1, 32'h0, "rd_snap", rd);
      check("rd_snap.val", rd, 32'h1234);
      txn(1'b0, 3'd0, 32'h0, "rd_live", rd);
      check("rd_live.val", rd, 32'h1300);

      cnt_value = 32'h0;
      txn(1'b1, 3'd2, 32'd5, "wr_cmp5", rd);
      txn(1'b1, 3'd3, 32'h1, "wr_en", rd);
      for (int v = 1; v <= 8; v++) begin
         cnt_value = 32'(v);
         for (int j = 0; j < 4; j++) begin
            step();
            check("ramp1.irq", 32'(irq), 32'(m_irq));
            if (v == 5 && j == 0) check("ramp1.irq_lag", 32'(irq), 32'd0);
            if (v == 5 && j == 1) check("ramp1.irq_rise", 32'(irq), 32'd1);
         end
      end
      txn(1'b0, 3'd3, 32'h0, "rd_ctrl_fired", rd);
      check("rd_ctrl_fired.val", rd, 32'h3);
      txn(1'b1, 3'd3, 32'h3, "w1c", rd);
      check("w1c.irq_low", 32'(irq), 32'd0);
      cnt_value = 32'h0;
      ramp("ramp2");
      txn(1'b0, 3'd3, 32'h0, "rd_ctrl_norefire", rd);
      check("rd_ctrl_norefire.val", rd, 32'h1);

      txn(1'b1, 3'd3, 32'h2, "dis", rd);
      cnt_value = 32'hFFFF_FFFE;
      txn(1'b1, 3'd2, 32'h0, "wr_cmp0", rd);
      cnt_value = 32'hFFFF_FFFF;
      repeat (2) step();
      cnt_value = 32'h0;
      repeat (2) step();
      txn(1'b0, 3'd3, 32'h0, "rd_ctrl_wrap", rd);
      check("rd_ctrl_wrap.val", rd, 32'h2);
      check("wrap.irq", 32'(irq), 32'd0);

      cnt_value = 32'hFFFF_FFFE;
      txn(1'b1, 3'd1, 32'h0, "snap_delta", rd);
      cnt_value = 32'h1;
      txn(1'b0, 3'd4, 32'h0, "rd_delta", rd);
`ifdef ARM_CLOCK_READER_DELTA_EN
      check("rd_delta.val", rd, 32'h3);
`else
      check("rd_delta.val", rd, 32'h0);
`endif

      cnt_value = $urandom;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) begin
            cnt_value = cnt_value + 32'd1;
            step();
            check("rand.irq", 32'(irq), 32'(m_irq));
         end
         a = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = (a == 3'd2) ? cnt_value + 32'($urandom_range(1, 4)) : $urandom;
         txn(w, a, d, "rand", rd);
      end

      cnt_value = 32'd42;
      txn(1'b1, 3'd1, 32'h0, "pre_snap", rd);
      txn(1'b1, 3'd2, 32'h77, "pre_cmp", rd);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0; resp_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         cnt_value = cnt_value + 32'd1;
         step();
         check("hold.req_ready", 32'(req_ready), 32'd0);
         check("hold.resp_valid", 32'(resp_valid), 32'd1);
         check("hold.rdata", resp_rdata, 32'd42);
      end
      cnt_resetn = 1'b0;
      step();
      check("midrst.resp_valid", 32'(resp_valid), 32'd0);
      check("midrst.irq", 32'(irq), 32'd0);
      cnt_resetn = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      step();
      txn(1'b0, 3'd3, 32'h0, "post_ctrl", rd);
      check("post_ctrl.val", rd, 32'h0);
      txn(1'b0, 3'd2, 32'h0, "post_cmp", rd);
      check("post_cmp.val", rd, 32'hFFFF_FFFF);
      txn(1'b0, 3'd1, 32'h0, "post_snap", rd);
      check("post_snap.val", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm_clock_reader.md
Name: arm_clock_reader

Overview:
- CPU-facing read/compare block for the free-running millisecond-scale count (`cnt_value`) produced by the clock counter.
- Samples the count through a small valid/ready register interface.
- Keeps a software-triggered snapshot and raises a one-shot compare-match interrupt.
- Sits between the counter output and the ARM-side bus adapter, in the counter's clock domain.

Parameters:
- ADDR_W, 3: width of `req_addr`; registers decoded from the low 3 bits, upper bits must be zero or the access is treated as unmapped.
- CMP_RESET, 32'hFFFF_FFFF: reset value of the compare register.

Ports:
- cnt_clk  in  1  single clock for the block.
- cnt_resetn  in  1  reset, synchronous, active-low.
- cnt_value  in  32  current count from the counter block; changes by +1 or wraps 0xFFFF_FFFF->0.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  register index.
- req_wdata  in  32  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  read data; 0 for writes and unmapped reads.
- irq  out  1  registered interrupt, level.

Behaviour:
- Interface: one clock, `cnt_clk`; reset `cnt_resetn` is synchronous and active-low.
- Reset values: all outputs 0 except `req_ready`=1 after the first clock with `cnt_resetn`=1. Register reset values: snap=0, cmp=CMP_RESET, irq_en=0, pending=0, armed=0, cnt_prev=0.
- FSM has two states, IDLE and RESP.
  - IDLE: `req_ready`=1. On `req_valid`&`req_ready`, the access executes in that cycle, `resp_rdata` is registered, and the FSM moves to RESP.
  - RESP: `resp_valid`=1, `req_ready`=0. `resp_rdata` is held stable until `resp_valid`&`resp_ready`, then the FSM returns to IDLE.
- Throughput: response is valid the cycle after accept; at most one transaction per 2 cycles.
- Register map:
  - addr0 LIVE (RO): returns `cnt_value` as sampled in the accept cycle.
  - addr1 SNAP: read returns snap. Write sets snap <= `cnt_value` of the accept cycle; wdata is ignored.
  - addr2 CMP (RW): a write loads cmp and sets armed=1.
  - addr3 CTRL (RW), read = {29'b0, armed, pending, irq_en}:
    - write bit0 -> irq_en;
    - bit1 =1 clears pending (W1C);
    - bit2 is ignored (armed is RO).
  - Other addresses: read 0; writes are ignored; a response is still returned.
- Writes to RO addr0 are ignored.
- Compare logic:
  - cnt_prev <= `cnt_value` every cycle.
  - tick = (`cnt_value` != cnt_prev).
  - match = tick & armed & (`cnt_value` == cmp).
  - On match: pending <= 1 and armed <= 0 (one-shot).
- Interrupt: `irq` <= pending & irq_en, registered, so `irq` rises 1 cycle after pending is set.
- Arithmetic: equality compare only, so wrap-around is natural. cmp=0 matches on the 0xFFFF_FFFF->0 tick. A count that is static, with no tick, never re-matches.
- Simultaneous events:
  - W1C of pending in the same cycle as a match: set wins, pending stays 1.
  - CMP write in the same cycle as a match against the old cmp: pending set; armed=1 (write wins); cmp takes the new value.
  - Clearing irq_en deasserts `irq` next cycle; pending is kept.
- Reset mid-transaction: any outstanding response is dropped (`resp_valid`=0 next cycle). All state returns to reset values and the FSM goes to IDLE.

Optional Feature:
- Macro ARM_CLOCK_READER_DELTA_EN.
- Defined: addr4 DELTA (RO) returns (`cnt_value` - snap) mod 2^32, computed in the accept cycle. Example: snap=0xFFFF_FFFE, cnt=0x1 -> 0x3.
- Not defined: addr4 behaves as unmapped (reads 0) and no subtractor is instantiated.

Test Plan:
- Reset, then read addr3 -> resp_rdata=0x0; read addr2 -> 0xFFFF_FFFF; `irq`=0.
- Hold `cnt_value`=0x1234, write addr1, then drive `cnt_value`=0x1300 and read addr1 -> 0x1234; read addr0 -> 0x1300; each response valid exactly 1 cycle after accept.
- Write CMP=5 and CTRL=0x1, ramp `cnt_value` 0..8 one per 4 cycles:
  - pending=1 on the 4->5 tick; `irq`=1 one cycle later;
  - write CTRL=0x3 clears pending, `irq` drops next cycle;
  - no re-fire at the next 5.
- Write CMP=0, step `cnt_value` 0xFFFF_FFFE->0xFFFF_FFFF->0 -> match on the wrap tick; read addr3 -> 0x2 (irq_en=0).
- Hold `resp_ready`=0 for 5 cycles with `req_valid`=1 -> `req_ready`=0, `resp_rdata` stable; assert `cnt_resetn`=0 mid-hold -> `resp_valid`=0 next cycle, all registers at reset values.
- With ARM_CLOCK_READER_DELTA_EN: snap=0xFFFF_FFFE, `cnt_value`=0x1, read addr4 -> 0x3. Without the macro, the same read -> 0x0.
